// File: rtl/sar_pkg.sv
// Constants and FSM encoding shared by the SAR conversion sequencer and
// the SAR logic's behavioural model.
package sar_pkg;

    localparam int unsigned N_BIT      = 8;
    localparam int unsigned BIT_PERIOD = 6;
    localparam int unsigned FIRST_CAPT = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        CONV  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sar_rr_pick.sv
// Round-robin finder: first enabled channel strictly after ptr, modulo N_CH.
// wrapped is set when the chosen index is not above ptr (scan wrapped around).
module sar_rr_pick
    import sar_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    localparam int unsigned CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] mask,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] next_idx,
    output logic            found,
    output logic            wrapped
);

    int unsigned     cand;
    logic [CH_W-1:0] cand_idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        next_idx = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned ofs = N_CH; ofs >= 1; ofs--) begin
            cand = 32'(ptr) + ofs;
            if (cand >= N_CH) begin
                cand = cand - N_CH;
            end
            cand_idx = CH_W'(cand);
            if (mask[cand_idx]) begin
                next_idx = cand_idx;
            end
        end
        found   = |mask;
        wrapped = found && (next_idx <= ptr);
    end

endmodule

// File: rtl/sar_conv_ctrl.sv
// SAR ADC conversion sequencer: track/convert timing, round-robin channel
// scan, serial-to-parallel capture and result handshake.
module sar_conv_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned TRACK_CYC = 12,
    localparam int unsigned CH_W     = ch_width(N_CH)
) (
    input  logic             CLK,
    input  logic             XRST,
    input  logic             START,
    input  logic             CONT,
    input  logic [N_CH-1:0]  CH_EN,
    input  logic             SAR_DOUT,
    input  logic             RESULT_READY,
    output logic             SAR_XRST,
    output logic             SAMPLE,
    output logic [CH_W-1:0]  CH_SEL,
    output logic             BUSY,
    output logic [N_BIT-1:0] RESULT,
    output logic [CH_W-1:0]  RESULT_CH,
    output logic             RESULT_VALID
);

    localparam int unsigned CNT_MAX =
        (TRACK_CYC > FIRST_CAPT) ? ((TRACK_CYC > BIT_PERIOD) ? TRACK_CYC : BIT_PERIOD)
                                 : ((FIRST_CAPT > BIT_PERIOD) ? FIRST_CAPT : BIT_PERIOD);
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W = $clog2(N_BIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [N_BIT-1:0] shreg_q, shreg_d;
    logic [N_BIT-1:0] result_q, result_d;
    logic [CH_W-1:0]  ptr_q, ptr_d;
    logic [CH_W-1:0]  ch_sel_q, ch_sel_d;
    logic [CH_W-1:0]  result_ch_q, result_ch_d;
    logic             valid_q, valid_d;
    logic             sar_xrst_q, sar_xrst_d;
    logic             sample_q, sample_d;
    logic             busy_q, busy_d;
    logic             pass_q, pass_d;

    logic [CH_W-1:0]  pick_ptr, pick_idx;
    logic             pick_found, pick_wrap;

    sar_rr_pick #(.N_CH(N_CH)) u_pick (
        .mask     (CH_EN),
        .ptr      (pick_ptr),
        .next_idx (pick_idx),
        .found    (pick_found),
        .wrapped  (pick_wrap)
    );

    // cnt_q counts down to the next event: end of tracking, or the next
    // SAR_DOUT capture (first after FIRST_CAPT cycles, then every BIT_PERIOD).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        result_d    = result_q;
        ptr_d       = ptr_q;
        ch_sel_d    = ch_sel_q;
        result_ch_d = result_ch_q;
        valid_d     = valid_q & ~RESULT_READY;
        sar_xrst_d  = sar_xrst_q;
        sample_d    = sample_q;
        pass_d      = pass_q;
        pick_ptr    = (state_q == DONE) ? ch_sel_q : ptr_q;

        unique case (state_q)
            IDLE: begin
                if ((START || CONT) && pick_found) begin
                    ch_sel_d   = pick_idx;
                    pass_d     = START;
                    cnt_d      = CNT_W'(TRACK_CYC - 1);
                    sample_d   = 1'b1;
                    sar_xrst_d = 1'b0;
                    state_d    = TRACK;
                end
            end
            TRACK: begin
                if (cnt_q == '0) begin
                    sample_d   = 1'b0;
                    sar_xrst_d = 1'b1;
                    cnt_d      = CNT_W'(FIRST_CAPT);
                    bit_d      = '0;
                    shreg_d    = '0;
                    state_d    = CONV;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CONV: begin
                if (cnt_q == '0) begin
                    shreg_d = {shreg_q[N_BIT-2:0], SAR_DOUT};
                    cnt_d   = CNT_W'(BIT_PERIOD - 1);
                    if (bit_q == BIT_W'(N_BIT - 1)) begin
                        state_d = DONE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                sar_xrst_d = 1'b0;
                if (!valid_q || RESULT_READY) begin
                    result_d    = shreg_q;
                    result_ch_d = ch_sel_q;
                    valid_d     = 1'b1;
                    ptr_d       = ch_sel_q;
                    pass_d      = pass_q & ~pick_wrap;
                    if ((CONT || (pass_q && !pick_wrap)) && pick_found) begin
                        ch_sel_d = pick_idx;
                        cnt_d    = CNT_W'(TRACK_CYC - 1);
                        sample_d = 1'b1;
                        state_d  = TRACK;
                    end else begin
                        pass_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            result_q    <= '0;
            ptr_q       <= CH_W'(N_CH - 1);
            ch_sel_q    <= '0;
            result_ch_q <= '0;
            valid_q     <= 1'b0;
            sar_xrst_q  <= 1'b0;
            sample_q    <= 1'b0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            result_q    <= result_d;
            ptr_q       <= ptr_d;
            ch_sel_q    <= ch_sel_d;
            result_ch_q <= result_ch_d;
            valid_q     <= valid_d;
            sar_xrst_q  <= sar_xrst_d;
            sample_q    <= sample_d;
            busy_q      <= busy_d;
            pass_q      <= pass_d;
        end
    end

    assign SAR_XRST     = sar_xrst_q;
    assign SAMPLE       = sample_q;
    assign CH_SEL       = ch_sel_q;
    assign BUSY         = busy_q;
    assign RESULT       = result_q;
    assign RESULT_CH    = result_ch_q;
    assign RESULT_VALID = valid_q;

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Directed bench for sar_conv_ctrl with a bit-serial SAR model that drives
// a per-channel code MSB first at the documented capture instants.
module tb_sar_conv_ctrl;
    import sar_pkg::*;

    logic             clk = 1'b0;
    logic             xrst = 1'b0;
    logic             start = 1'b0;
    logic             cont = 1'b0;
    logic [3:0]       ch_en = 4'b0000;
    logic             sar_dout = 1'b0;
    logic             result_ready = 1'b1;
    logic             sar_xrst, sample, busy, result_valid;
    logic [1:0]       ch_sel, result_ch;
    logic [N_BIT-1:0] result;

    logic [N_BIT-1:0] ch_code [4];
    logic [N_BIT-1:0] mcode;
    int               m = 0;
    int               k;
    int               samp_hi = 0, xr_hi = 0, samp_rise = 0;
    logic             sample_prev = 1'b0;
    int               vecs = 0, miss = 0;

    sar_conv_ctrl #(.N_CH(4), .TRACK_CYC(12)) dut (
        .CLK          (clk),
        .XRST         (xrst),
        .START        (start),
        .CONT         (cont),
        .CH_EN        (ch_en),
        .SAR_DOUT     (sar_dout),
        .RESULT_READY (result_ready),
        .SAR_XRST     (sar_xrst),
        .SAMPLE       (sample),
        .CH_SEL       (ch_sel),
        .BUSY         (busy),
        .RESULT       (result),
        .RESULT_CH    (result_ch),
        .RESULT_VALID (result_valid)
    );

    always #5 clk = ~clk;

    // SAR model: m = cycles since SAR_XRST rose; bit k valid from FIRST_CAPT + k*BIT_PERIOD
    always @(negedge clk) begin
        if (sar_xrst) begin
            k = (m < int'(FIRST_CAPT)) ? 0 : (m - int'(FIRST_CAPT)) / int'(BIT_PERIOD);
            if (k > int'(N_BIT) - 1) k = int'(N_BIT) - 1;
            mcode    = ch_code[ch_sel];
            sar_dout = mcode[int'(N_BIT) - 1 - k];
            m++;
        end else begin
            m        = 0;
            sar_dout = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (sample) samp_hi++;
        if (sar_xrst) xr_hi++;
        if (sample && !sample_prev) samp_rise++;
        sample_prev = sample;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(input int budget, output bit got, output int n);
        got = 1'b0;
        n   = 0;
        while (!got && n < budget) begin
            @(negedge clk);
            n++;
            if (result_valid) got = 1'b1;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vecs++;
        if ({sar_xrst, sample, ch_sel, busy, result, result_ch, result_valid} !== '0) begin
            miss++;
            $display("FAIL reset_outputs: got xrst=%b smp=%b sel=%0d busy=%b res=%h ch=%0d v=%b, required all 0",
                     sar_xrst, sample, ch_sel, busy, result, result_ch, result_valid);
        end
        xrst = 1'b1;
    endtask

    task automatic test_single();
        bit got;
        int n;
        ch_code[0]   = 8'hA5;
        ch_en        = 4'b0001;
        result_ready = 1'b1;
        @(negedge clk);
        samp_hi = 0;
        xr_hi   = 0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(100, got, n);
        vecs++;
        if (!got || n != 63) begin
            miss++;
            $display("FAIL single_latency: got %0d (valid=%b), required 63", n, got);
        end
        vecs++;
        if (result !== 8'hA5 || result_ch !== 2'd0) begin
            miss++;
            $display("FAIL single_result: got ch%0d %h, required ch0 a5", result_ch, result);
        end
        vecs++;
        if (samp_hi != 12) begin
            miss++;
            $display("FAIL single_sample_width: got %0d, required 12", samp_hi);
        end
        vecs++;
        if (xr_hi != 51) begin
            miss++;
            $display("FAIL single_sar_xrst_width: got %0d, required 51", xr_hi);
        end
        vecs++;
        if (busy !== 1'b0) begin
            miss++;
            $display("FAIL single_busy_end: got %b, required 0", busy);
        end
    endtask

    task automatic test_scan_pass();
        bit got;
        int n;
        ch_code[1] = 8'h3C;
        ch_code[3] = 8'hC3;
        ch_en      = 4'b1010;
        pulse_start();
        wait_valid(100, got, n);
        vecs++;
        if (!got || result !== 8'h3C || result_ch !== 2'd1) begin
            miss++;
            $display("FAIL pass_first: got ch%0d %h (valid=%b), required ch1 3c", result_ch, result, got);
        end
        wait_valid(100, got, n);
        vecs++;
        if (!got || result !== 8'hC3 || result_ch !== 2'd3) begin
            miss++;
            $display("FAIL pass_second: got ch%0d %h (valid=%b), required ch3 c3", result_ch, result, got);
        end
        samp_rise = 0;
        wait_valid(120, got, n);
        vecs++;
        if (got || samp_rise != 0 || busy !== 1'b0) begin
            miss++;
            $display("FAIL pass_no_third: got valid=%b tracks=%0d busy=%b, required 0 0 0", got, samp_rise, busy);
        end
    endtask

    task automatic test_cont_scan();
        bit   got;
        int   n;
        logic [1:0] exp_ch;
        ch_code[0]   = 8'h11;
        ch_code[1]   = 8'h22;
        ch_code[2]   = 8'h33;
        ch_code[3]   = 8'h44;
        ch_en        = 4'b1111;
        result_ready = 1'b1;
        @(negedge clk);
        cont = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_ch = 2'(i % 4);
            wait_valid(100, got, n);
            vecs++;
            if (!got || result_ch !== exp_ch || result !== ch_code[exp_ch]) begin
                miss++;
                $display("FAIL cont_order[%0d]: got ch%0d %h (valid=%b), required ch%0d %h",
                         i, result_ch, result, got, exp_ch, ch_code[exp_ch]);
            end
            if (i > 0) begin
                vecs++;
                if (n != 63) begin
                    miss++;
                    $display("FAIL cont_spacing[%0d]: got %0d, required 63", i, n);
                end
            end
        end
        repeat (30) @(negedge clk);
        cont = 1'b0;
        wait_valid(100, got, n);
        vecs++;
        if (!got || result_ch !== 2'd2 || result !== 8'h33 || busy !== 1'b0) begin
            miss++;
            $display("FAIL cont_drop: got ch%0d %h valid=%b busy=%b, required ch2 33 1 0",
                     result_ch, result, got, busy);
        end
        samp_rise = 0;
        wait_valid(150, got, n);
        vecs++;
        if (got || samp_rise != 0) begin
            miss++;
            $display("FAIL cont_idle_after: got valid=%b tracks=%0d, required 0 0", got, samp_rise);
        end
    endtask

    task automatic test_backpressure();
        bit got;
        int n;
        bit unstable;
        ch_en        = 4'b1111;
        result_ready = 1'b0;
        @(negedge clk);
        cont = 1'b1;
        wait_valid(100, got, n);
        vecs++;
        if (!got || result_ch !== 2'd3 || result !== 8'h44) begin
            miss++;
            $display("FAIL bp_first: got ch%0d %h (valid=%b), required ch3 44", result_ch, result, got);
        end
        unstable = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (result !== 8'h44 || result_ch !== 2'd3 || result_valid !== 1'b1) unstable = 1'b1;
        end
        vecs++;
        if (unstable) begin
            miss++;
            $display("FAIL bp_hold: got change in held result, required stable ch3 44 valid");
        end
        vecs++;
        if (sar_xrst !== 1'b0 || sample !== 1'b0 || busy !== 1'b1) begin
            miss++;
            $display("FAIL bp_wait_done: got xrst=%b smp=%b busy=%b, required 0 0 1", sar_xrst, sample, busy);
        end
        result_ready = 1'b1;
        cont         = 1'b0;
        @(negedge clk);
        vecs++;
        if (result_valid !== 1'b1 || result_ch !== 2'd0 || result !== 8'h11) begin
            miss++;
            $display("FAIL bp_reload: got ch%0d %h valid=%b, required ch0 11 1", result_ch, result, result_valid);
        end
        @(negedge clk);
        vecs++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            miss++;
            $display("FAIL bp_drain: got valid=%b busy=%b, required 0 0", result_valid, busy);
        end
    endtask

    task automatic test_no_enable();
        bit busy_seen;
        ch_en     = 4'b0000;
        samp_rise = 0;
        @(negedge clk);
        start = 1'b1;
        cont  = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        busy_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        cont = 1'b0;
        vecs++;
        if (busy_seen || samp_rise != 0) begin
            miss++;
            $display("FAIL no_enable: got busy=%b tracks=%0d, required 0 0", busy_seen, samp_rise);
        end
    endtask

    task automatic test_start_during_conv();
        bit got;
        int n;
        ch_code[0] = 8'h5A;
        ch_en      = 4'b0001;
        samp_rise  = 0;
        pulse_start();
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(100, got, n);
        vecs++;
        if (!got || result_ch !== 2'd0 || result !== 8'h5A) begin
            miss++;
            $display("FAIL busy_start_result: got ch%0d %h (valid=%b), required ch0 5a", result_ch, result, got);
        end
        wait_valid(120, got, n);
        vecs++;
        if (got || samp_rise != 1) begin
            miss++;
            $display("FAIL busy_start_ignored: got valid=%b tracks=%0d, required 0 1", got, samp_rise);
        end
    endtask

    task automatic test_async_reset();
        bit got;
        int n;
        ch_code[0] = 8'hC6;
        ch_en      = 4'b0001;
        pulse_start();
        repeat (44) @(negedge clk);
        vecs++;
        if (sar_xrst !== 1'b1 || busy !== 1'b1) begin
            miss++;
            $display("FAIL arst_pre: got xrst=%b busy=%b, required 1 1", sar_xrst, busy);
        end
        #2 xrst = 1'b0;
        #1;
        vecs++;
        if ({sar_xrst, sample, ch_sel, busy, result, result_ch, result_valid} !== '0) begin
            miss++;
            $display("FAIL arst_outputs: got xrst=%b smp=%b sel=%0d busy=%b res=%h ch=%0d v=%b, required all 0",
                     sar_xrst, sample, ch_sel, busy, result, result_ch, result_valid);
        end
        @(negedge clk);
        xrst       = 1'b1;
        ch_code[0] = 8'h69;
        pulse_start();
        wait_valid(100, got, n);
        vecs++;
        if (!got || n != 63 || result_ch !== 2'd0 || result !== 8'h69) begin
            miss++;
            $display("FAIL arst_recover: got ch%0d %h lat=%0d valid=%b, required ch0 69 lat 63",
                     result_ch, result, n, got);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_scan_pass();
        test_cont_scan();
        test_backpressure();
        test_no_enable();
        test_start_during_conv();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/sar_conv_ctrl.md
Name: sar_conv_ctrl

Overview:
Conversion sequencer for the 8-bit SAR ADC. Sequences track (sample) and convert phases, and holds the SAR logic in reset between conversions. Scans enabled input channels round-robin and deserialises the SAR's MSB-first serial bit stream into a channel-tagged result word. Sits between the register/host side (start, mode, channel mask, result handshake) and the SAR logic, S/H switch and analog input mux.

Parameters:
N_BIT, 8, ADC resolution; bits captured per conversion
N_CH, 4, number of analog input channels (CH_W = clog2(N_CH), minimum 1)
TRACK_CYC, 12, CLK cycles SAMPLE stays high before conversion starts (≥1)
BIT_PERIOD, 6, CLK cycles per SAR bit decision
FIRST_CAPT, 7, CLK cycles from SAR_XRST rising to first valid SAR_DOUT sample

Ports:
CLK  in  1  system clock (48 MHz PLL output)
XRST  in  1  asynchronous active-low reset; one clock domain (CLK), reset is asynchronous and active-low
START  in  1  single-shot request pulse; one scan pass over enabled channels
CONT  in  1  level; continuous scanning while high
CH_EN  in  N_CH  channel enable mask
SAR_DOUT  in  1  per-bit decision from SAR logic (its DIGITAL_OUT)
RESULT_READY  in  1  consumer accepts result
SAR_XRST  out  1  reset to SAR logic; low holds it idle
SAMPLE  out  1  S/H track switch, high = track
CH_SEL  out  CH_W  analog mux select
BUSY  out  1  high in any state other than IDLE
RESULT  out  N_BIT  converted code
RESULT_CH  out  CH_W  channel of RESULT
RESULT_VALID  out  1  RESULT/RESULT_CH valid

Behaviour:
- Reset values: SAR_XRST=0, SAMPLE=0, CH_SEL=0, BUSY=0, RESULT=0, RESULT_CH=0, RESULT_VALID=0. FSM=IDLE, round-robin pointer=N_CH-1, so channel 0 is picked first. All outputs are registered.
- FSM states: IDLE, TRACK, CONV, DONE.
- IDLE:
  - Leave IDLE on START=1 or CONT=1, and only when CH_EN≠0. With CH_EN=0, both are ignored.
  - Next channel = first enabled channel strictly after the pointer, wrapping modulo N_CH. Load it into CH_SEL and go to TRACK.
  - START latches a scan-pass flag. The pass ends once the highest-index enabled channel has been converted.
- TRACK:
  - SAMPLE=1 for exactly TRACK_CYC cycles; SAR_XRST=0.
  - Then SAMPLE=0 and SAR_XRST=1 on the same edge; go to CONV.
- CONV:
  - Cycle counter starts at 0 on the SAR_XRST rising edge.
  - SAR_DOUT is sampled at count FIRST_CAPT + k·BIT_PERIOD, for k=0..N_BIT-1.
  - Shift register shifts left, MSB first: bit k lands at position N_BIT-1-k.
  - After the last capture, SAR_XRST=0 on the next edge; go to DONE.
- DONE:
  - If RESULT_VALID=0, or RESULT_VALID=1 with RESULT_READY=1 in this cycle, load RESULT, RESULT_CH=CH_SEL and RESULT_VALID=1. Update the pointer to CH_SEL.
  - Otherwise stay in DONE with SAR held in reset. No data is dropped.
  - After loading, next state:
    - If CONT=1, or the scan pass is unfinished, and CH_EN≠0: pick the next channel and go to TRACK.
    - Else go to IDLE.
- Output handshake: RESULT_VALID clears on RESULT_READY=1 unless a new result loads in the same cycle. RESULT and RESULT_CH are stable while VALID=1 and READY=0.
- CH_EN is sampled only at channel-pick points. Changing it mid-conversion does not affect the channel in flight.
- START while BUSY=1 is ignored.
- CONT falling mid-conversion: the current conversion completes and is delivered, then the FSM goes to IDLE unless a START pass is pending.
- Asynchronous reset mid-conversion: immediate return to the reset values. The partial result is discarded.
- Conversion latency: TRACK_CYC + FIRST_CAPT + (N_BIT-1)·BIT_PERIOD + 2 cycles from leaving IDLE to RESULT_VALID, with READY held high. Defaults give 12+7+42+2 = 63.

Decomposition:
- Shared package sar_pkg: N_BIT, BIT_PERIOD, FIRST_CAPT, and the FSM state encoding (IDLE=0, TRACK=1, CONV=2, DONE=3). The same constants are reused by the SAR logic's testbench model.
- One sub-module, sar_rr_pick: combinational round-robin next-enabled-channel finder. Inputs: mask, pointer. Outputs: next index, found flag, wrapped flag. The wrapped flag is used for scan-pass end detection.

Test Plan:
- Single shot, CH_EN=4'b0001, SAR model drives code 8'hA5 bit-serially → RESULT=8'hA5, RESULT_CH=0, VALID at cycle 63. SAMPLE high for 12 cycles, SAR_XRST high for 51 cycles. BUSY returns to 0.
- START with CH_EN=4'b1010, codes 8'h3C then 8'hC3 → results (ch1, 8'h3C) then (ch3, 8'hC3), then IDLE. No third conversion.
- CONT=1, CH_EN=4'b1111, RESULT_READY=1 → channel order 0,1,2,3,0,1…. CONT dropped during ch2 CONV → ch2 delivered, then IDLE.
- Backpressure: RESULT_READY=0 for 100 cycles in CONT mode → first result held stable. FSM waits in DONE with SAR_XRST=0. On READY=1, second result loads in the same cycle VALID would clear.
- START with CH_EN=0 → BUSY stays 0, no SAMPLE pulse. START during CONV → ignored, single result.
- XRST asserted at CONV bit 4 → all outputs at reset values asynchronously. Next START converts channel 0 cleanly with the correct code.
